// File: rtl/sw_debounce8.sv
// ---------------------------------------------------------------------------
// sw_debounce8 -- eight-switch debouncer feeding a downstream 8-to-3 encoder.
//
// Every raw switch bit and the raw enable pass through a two-flop
// synchronizer. Each switch bit then has its own stable-run counter. A new
// level is accepted only after DEBOUNCE_CYCLES consecutive cycles that
// disagree with the current output. o_chg pulses for one cycle after any
// edge at which o_code changes.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level
//                    (2 .. 2^20-1)
//
// Ports
//   i_clk      single clock, rising edge
//   i_rst_n    synchronous reset, active low
//   i_sw[7:0]  raw asynchronous slide-switch levels
//   i_en       raw asynchronous enable switch
//   o_code     debounced switch vector
//   o_en       synchronized enable (two-cycle latency, not debounced)
//   o_chg      one-cycle pulse following any o_code update
//   o_chg_cnt  wrapping count of o_chg pulses; present only when the
//              SW_DEBOUNCE_CHG_CNT_EN macro is defined
// ---------------------------------------------------------------------------

// Per-bit debounce counter and accepted level.
module sw_debounce8_lane #(
    parameter logic [19:0] LAST = 20'd3    // DEBOUNCE_CYCLES-1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_s2,      // synchronized switch level
    output logic o_level,   // accepted (debounced) level
    output logic o_load     // high in the cycle that o_level is about to update
);
    logic [19:0] cnt_q, cnt_d;
    logic        lvl_q, lvl_d;
    logic        load;

    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        load  = 1'b0;
        if (i_s2 == lvl_q) begin
            // Any agreement (including a bounce back) throws away the run.
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            lvl_d = i_s2;
            cnt_d = '0;
            load  = 1'b1;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign o_level = lvl_q;
    assign o_load  = load;
endmodule

module sw_debounce8 #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_sw,
    input  logic       i_en,
    output logic [7:0] o_code,
    output logic       o_en,
`ifdef SW_DEBOUNCE_CHG_CNT_EN
    output logic       o_chg,
    output logic [7:0] o_chg_cnt
`else
    output logic       o_chg
`endif
);
    localparam logic [19:0] LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic [7:0] sw_s1_q, sw_s2_q;
    logic       en_s1_q, en_s2_q;
    logic [7:0] load;
    logic       chg_q, chg_d;

    // Two-flop synchronizers; nothing downstream looks at s1.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            en_s1_q <= 1'b0;
            en_s2_q <= 1'b0;
        end else begin
            sw_s1_q <= i_sw;
            sw_s2_q <= sw_s1_q;
            en_s1_q <= i_en;
            en_s2_q <= en_s1_q;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_lane
        sw_debounce8_lane #(.LAST(LAST)) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_s2    (sw_s2_q[g]),
            .o_level (o_code[g]),
            .o_load  (load[g])
        );
    end

    // Bits accepted on the same edge merge into one pulse.
    assign chg_d = |load;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) chg_q <= 1'b0;
        else          chg_q <= chg_d;
    end

    assign o_en  = en_s2_q;
    assign o_chg = chg_q;

`ifdef SW_DEBOUNCE_CHG_CNT_EN
    logic [7:0] chg_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)   chg_cnt_q <= '0;
        else if (chg_q) chg_cnt_q <= chg_cnt_q + 8'd1;
    end

    assign o_chg_cnt = chg_cnt_q;
`endif
endmodule

// File: doc/sw_debounce8.md
SW_DEBOUNCE8 -- requirements
Module: sw_debounce8

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a new level; legal range 2..2^20-1.
REQ-002 Port i_clk, input, 1: single clock, rising edge.
REQ-003 Port i_rst_n, input, 1: reset, synchronous and active-low.
REQ-004 Port i_sw, input, 8: raw asynchronous slide-switch levels.
REQ-005 Port i_en, input, 1: raw asynchronous enable switch.
REQ-006 Port o_code, output, 8: debounced switch vector, the one-hot/priority input of the downstream 8-to-3 encoder.
REQ-007 Port o_en, output, 1: synchronized enable for the downstream encoder.
REQ-008 Port o_chg, output, 1: one-cycle pulse when any bit of o_code changes.

Function
REQ-009 Each i_sw bit and i_en SHALL pass through a two-flop synchronizer (s1, then s2) before any use.
REQ-010 o_en SHALL equal the s2 stage of i_en: no debouncing, 2-cycle latency.
REQ-011 Each o_code bit SHALL own an independent 20-bit saturating-free counter cnt[i].
REQ-012 While s2[i] equals o_code[i], cnt[i] SHALL be cleared to 0 every cycle.
REQ-013 While s2[i] differs from o_code[i] and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-014 When s2[i] differs from o_code[i] and cnt[i] == DEBOUNCE_CYCLES-1, o_code[i] SHALL load s2[i] and cnt[i] SHALL clear, on the same edge.
REQ-015 Latency: a clean level change on i_sw[i] first sampled at edge 1 SHALL appear on o_code[i] at edge DEBOUNCE_CYCLES+2.
REQ-016 Bounce: any return of s2[i] to o_code[i] before acceptance SHALL clear cnt[i]; o_code[i] and o_chg SHALL remain unchanged.
REQ-017 o_chg SHALL be registered: high for exactly the one cycle following any edge at which at least one o_code bit updates, otherwise low.
REQ-018 Several bits accepted at the same edge SHALL produce a single o_chg pulse; bits accepted at different edges SHALL produce separate pulses.
REQ-019 Counters SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 With i_rst_n low at a rising edge: s1, s2, o_code = 8'h00; o_en = 0; o_chg = 0; all cnt = 0.
REQ-021 Reset asserted mid-count SHALL discard partial counts; after release, debouncing SHALL restart from 0 relative to the o_code value 8'h00.
REQ-022 A switch held high through reset SHALL be accepted DEBOUNCE_CYCLES+2 cycles after the first edge with i_rst_n high.

Configuration
REQ-023 Macro SW_DEBOUNCE_CHG_CNT_EN defined: add output o_chg_cnt, 8 bits, incremented by 1 (wrapping 8'hFF -> 8'h00) on every o_chg pulse, reset to 8'h00.
REQ-024 Macro SW_DEBOUNCE_CHG_CNT_EN undefined: o_chg_cnt port and counter SHALL be absent; all other behaviour identical.

Verification (DEBOUNCE_CYCLES = 4)
REQ-025 Reset, then i_sw = 8'h00 steady -> o_code = 8'h00, o_chg never pulses, o_en follows i_en 2 cycles later.
REQ-026 i_sw: 8'h00 -> 8'h10, first sampled at edge 1 -> o_code = 8'h10 at edge 6, o_chg high for one cycle only.
REQ-027 i_sw[3] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no o_code change during the toggling; o_code[3] = 1 exactly 6 edges after the final rise is first sampled.
REQ-028 i_sw 8'h00 -> 8'h81 in one cycle -> both bits accepted at the same edge, single o_chg pulse; then bit 0 released and bit 7 released 3 cycles apart -> two distinct o_chg pulses.
REQ-029 i_sw = 8'hFF, i_rst_n low for 1 cycle at count 2 -> o_code = 8'h00 during reset; 8'hFF accepted 6 edges after reset release.
REQ-030 With SW_DEBOUNCE_CHG_CNT_EN defined, 257 accepted changes -> o_chg_cnt = 8'h01.
